// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: shared types for the GPIO handshake sequencer.
// Step entry layout, FSM states and wait-mode encodings.
package gpio_seq_pkg;

    localparam int SEQ_IDX_W = 8;
    localparam int SEQ_DLY_W = 16;

    localparam logic [1:0] WAIT_NONE = 2'b00;
    localparam logic [1:0] WAIT_HI   = 2'b01;
    localparam logic [1:0] WAIT_LO   = 2'b10;
    localparam logic [1:0] WAIT_RISE = 2'b11;

    typedef struct packed {
        logic                 last;
        logic                 drv_en;
        logic                 drv_val;
        logic [SEQ_IDX_W-1:0] drv_idx;
        logic [1:0]           wait_mode;
        logic [SEQ_IDX_W-1:0] wait_idx;
        logic [SEQ_DLY_W-1:0] delay;
    } step_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/gpio_seq_table.sv
// gpio_seq_table: DEPTH x step_t register file.
// One synchronous write port, one asynchronous read port, no reset.
module gpio_seq_table
    import gpio_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  step_t         wdata,
    input  logic [AW-1:0] raddr,
    output step_t         rdata
);

    step_t mem_q [DEPTH];

    // Write port; contents are undefined until programmed
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/gpio_seq_sequencer.sv
// gpio_seq_sequencer: step-table driven gpio wait/drive sequencer.
// Optional per-step watchdog enabled by defining GPIO_SEQ_TIMEOUT_EN.
module gpio_seq_sequencer
    import gpio_seq_pkg::*;
#(
    parameter int                GPIO_W    = 32,
    parameter int                DEPTH     = 16,
    parameter int                DLY_W     = 16,
    parameter int                TMO_W     = 24,
    parameter logic [GPIO_W-1:0] GPIO_INIT = '0,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tbl_we,
    input  logic [AW-1:0]             tbl_addr,
    input  logic [$bits(step_t)-1:0]  tbl_wdata,
    input  logic                      start,
    input  logic                      abort,
    input  logic [TMO_W-1:0]          tmo_cycles,
    input  logic [GPIO_W-1:0]         gpio_out,
    output logic [GPIO_W-1:0]         gpio_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [AW-1:0]             step_idx
);

    localparam int            GB       = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [GPIO_W-1:0] prev_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    step_t             cur;
    logic              wait_ok, drv_ok, cond_met, fire, tmo_hit;
    logic [GB-1:0]     wait_bit, drv_bit;

    gpio_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .we    (tbl_we & ~busy_q),
        .waddr (tbl_addr),
        .wdata (step_t'(tbl_wdata)),
        .raddr (step_q),
        .rdata (cur)
    );

    assign wait_ok  = int'(cur.wait_idx) < GPIO_W;
    assign wait_bit = cur.wait_idx[GB-1:0];
    assign drv_ok   = cur.drv_en && (int'(cur.drv_idx) < GPIO_W);
    assign drv_bit  = cur.drv_idx[GB-1:0];

    // Evaluate the current step's wait condition; out-of-range bits count as met
    always_comb begin
        cond_met = 1'b1;
        if (wait_ok) begin
            unique case (cur.wait_mode)
                WAIT_HI:   cond_met = gpio_out[wait_bit];
                WAIT_LO:   cond_met = ~gpio_out[wait_bit];
                WAIT_RISE: cond_met = gpio_out[wait_bit] & ~prev_q[wait_bit];
                default:   cond_met = 1'b1;
            endcase
        end
    end

`ifdef GPIO_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Count consecutive unmet WAIT cycles; any other cycle restarts the count
    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT && !cond_met) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == S_WAIT) && !cond_met &&
                     (tmo_cycles != '0) &&
                     (tmo_q >= tmo_cycles - 1'b1);

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^tmo_cycles;
    assign tmo_hit    = 1'b0;
`endif

    // Next-state logic: step sequencing, delay countdown, drive, abort
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dly_d   = dly_q;
        gpio_d  = gpio_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        fire    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_WAIT;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (cond_met) begin
                    if (cur.delay == '0) begin
                        fire = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                        dly_d   = DLY_W'(cur.delay);
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_DELAY: begin
                if (dly_q <= DLY_W'(1)) begin
                    fire = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            if (drv_ok) begin
                gpio_d[drv_bit] = cur.drv_val;
            end
            if (cur.last || step_q == LAST_IDX) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = S_WAIT;
                step_d  = step_q + 1'b1;
            end
        end

        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            step_d  = step_q;
            gpio_d  = gpio_q;
            done_d  = done_q;
            err_d   = err_q;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            dly_q   <= '0;
            gpio_q  <= GPIO_INIT;
            prev_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dly_q   <= dly_d;
            gpio_q  <= gpio_d;
            prev_q  <= gpio_out;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign gpio_in  = gpio_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign step_idx = step_q;

endmodule
